pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline controller for the 5-stage MIPS core. It is the producer of the `stall[5:0]` vector and the `flush` strobe that every inter-stage latch consumes. It arbitrates per-stage stall requests, converts exceptions reported by the MEM stage into a one-cycle flush plus a redirect PC, and runs a stall watchdog and a stall-cycle performance counter.

## Interface
Parameters:
- `EBASE`, 32'h0000_0000: exception vector base; handler address is `EBASE + 32'h20`.
- `WDOG_LIMIT`, 16'd4096: number of consecutive stalled cycles that trips the watchdog.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stallreq_from_if`  in  1  IF is waiting on instruction fetch.
- `stallreq_from_id`  in  1  ID load-use or branch hazard.
- `stallreq_from_ex`  in  1  EX multi-cycle op (div, madd/msub) in progress.
- `stallreq_from_mem`  in  1  MEM is waiting on data access.
- `excepttype_i`  in  32  exception code from MEM; 0 means none.
- `cp0_epc_i`  in  32  current EPC, used for `eret`.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold.
- `flush`  out  1  kill all latches this cycle.
- `new_pc`  out  32  redirect target; valid only while `flush`=1, otherwise 0.
- `wdog_timeout`  out  1  sticky watchdog flag.
- `stall_cycles`  out  32  saturating count of cycles with `stall[0]`=1.

## Operation
- Stall decode uses priority mem > ex > id > if. mem gives 6'b011111, ex gives 6'b001111, id gives 6'b000111, if gives 6'b000011, and no request gives 6'b000000.
- Exception acceptance: `excepttype_i`≠0 and `stallreq_from_mem`=0 and state=RUN. When accepted, `flush`=1 and `stall`=0 in the same cycle, and the state moves to REFILL.
- Deferral: if `excepttype_i`≠0 while `stallreq_from_mem`=1, the mem stall vector is output and `flush`=0. The exception is accepted in the first cycle the mem stall drops.
- `new_pc` while flushing:
  - `excepttype_i`=32'h0000_000e (eret) gives `cp0_epc_i`.
  - Codes 0x1 (int), 0x8 (syscall), 0xa (RI), 0xc (Ov), 0xd (trap) give `EBASE+32'h20`.
  - Any other nonzero code is treated as 0x1.
- FSM:
  - RUN to REFILL on accepted exception.
  - REFILL to RUN unconditionally after 1 cycle.
  - In REFILL, `excepttype_i` is ignored (the bubble cannot except), `flush`=0, and stall decode operates normally.
- Watchdog: a 16-bit counter increments each cycle `stall[0]`=1 and clears on any cycle `stall[0]`=0. When it reaches `WDOG_LIMIT`, `wdog_timeout` is set; the counter then saturates and the flag clears only on reset.
- `stall_cycles` increments when `stall[0]`=1 and saturates at 32'hFFFF_FFFF.

## Timing
- `stall`, `flush`, and `new_pc` are combinational from the inputs and the state, with zero latency. The latches sample them at the same edge.
- State, the watchdog counter, `wdog_timeout`, and `stall_cycles` are registered and update on the rising edge.
- While `rst`=0:
  - State = RUN.
  - Watchdog counter = 0.
  - `wdog_timeout`=0 and `stall_cycles`=0.
  - Combinational outputs are forced: `stall`=0, `flush`=0, `new_pc`=0.
- Reset asserted during REFILL returns the FSM to RUN immediately (asynchronous).
- Flush dominates stall: no cycle has both `flush`=1 and `stall`≠0.

## Structure
- Shared package/defines: `Stop`/`NoStop`, `ZeroWord`, the stall vector bit positions, and the exception code constants (0x1, 0x8, 0xa, 0xc, 0xd, 0xe).
- Sub-module: `stall_wdog` (watchdog counter plus sticky flag). Everything else stays inline.

## Test plan
- Assert `stallreq_from_id`=1 alone for 3 cycles: `stall`=6'b000111 for 3 cycles; `stall_cycles` goes 0 to 3.
- Assert `stallreq_from_if`, `stallreq_from_ex`, and `stallreq_from_mem` together, then drop mem: `stall`=6'b011111, then 6'b001111.
- Set `excepttype_i`=32'h8 with EBASE=32'h0: `flush`=1, `new_pc`=32'h20, `stall`=0. On the next cycle, with `excepttype_i` still 32'h8, `flush`=0 (REFILL).
- Set `excepttype_i`=32'he with `cp0_epc_i`=32'h0000_1234 while `stallreq_from_mem`=1 for 2 cycles:
  - `stall`=6'b011111 and `flush`=0 for 2 cycles.
  - On the third cycle, `flush`=1 and `new_pc`=32'h1234.
- With WDOG_LIMIT=4, hold `stallreq_from_if` for 5 cycles: `wdog_timeout` rises after the 4th edge and stays 1 after the request drops. Pulsing `rst` low clears it along with `stall_cycles`.
- Drop `rst` asynchronously mid-REFILL: all outputs go to 0 immediately and the FSM restarts in RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall vectors, exception codes, FSM states.
package pipe_ctrl_pkg;

    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int unsigned StallPc  = 0;
    localparam int unsigned StallIf  = 1;
    localparam int unsigned StallId  = 2;
    localparam int unsigned StallEx  = 3;
    localparam int unsigned StallMem = 4;
    localparam int unsigned StallWb  = 5;

    localparam logic [5:0] StallVecNone = 6'b000000;
    localparam logic [5:0] StallVecIf   = 6'b000011;
    localparam logic [5:0] StallVecId   = 6'b000111;
    localparam logic [5:0] StallVecEx   = 6'b001111;
    localparam logic [5:0] StallVecMem  = 6'b011111;

    localparam logic [31:0] ExcInt     = 32'h0000_0001;
    localparam logic [31:0] ExcSyscall = 32'h0000_0008;
    localparam logic [31:0] ExcRi      = 32'h0000_000a;
    localparam logic [31:0] ExcOv      = 32'h0000_000c;
    localparam logic [31:0] ExcTrap    = 32'h0000_000d;
    localparam logic [31:0] ExcEret    = 32'h0000_000e;

    localparam logic [31:0] ExcOffset  = 32'h0000_0020;

    typedef enum logic [0:0] {
        StRun,
        StRefill
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky timeout flag.
module stall_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter logic [15:0] WDOG_LIMIT = 16'd4096
) (
    input  logic clk,
    input  logic rst,
    input  logic pc_stalled,
    output logic wdog_timeout
);

    logic [15:0] wdog_cnt;
    logic [16:0] cnt_inc;

    // Widened so the trip comparison cannot wrap at the counter's top value.
    assign cnt_inc = {1'b0, wdog_cnt} + 17'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt     <= '0;
            wdog_timeout <= 1'b0;
        end else if (pc_stalled == Stop) begin
            if (wdog_cnt < WDOG_LIMIT) begin
                wdog_cnt <= cnt_inc[15:0];
            end
            if (cnt_inc >= {1'b0, WDOG_LIMIT}) begin
                wdog_timeout <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, exception flush/redirect, watchdog and stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EBASE      = 32'h0000_0000,
    parameter logic [15:0] WDOG_LIMIT = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdog_timeout,
    output logic [31:0] stall_cycles
);

    ctrl_state_e state;
    logic        accept;

    // Exceptions are only taken once MEM is no longer stalled, and never from the refill bubble.
    assign accept = (excepttype_i != ZeroWord) && !stallreq_from_mem && (state == StRun);

    always_comb begin
        stall  = StallVecNone;
        flush  = NoStop;
        new_pc = ZeroWord;
        if (rst) begin
            if (accept) begin
                flush  = Stop;
                new_pc = (excepttype_i == ExcEret) ? cp0_epc_i : EBASE + ExcOffset;
            end else if (stallreq_from_mem) begin
                stall = StallVecMem;
            end else if (stallreq_from_ex) begin
                stall = StallVecEx;
            end else if (stallreq_from_id) begin
                stall = StallVecId;
            end else if (stallreq_from_if) begin
                stall = StallVecIf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StRun;
        end else begin
            unique case (state)
                StRun:    if (accept) state <= StRefill;
                StRefill: state <= StRun;
                default:  state <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall[StallPc] == Stop && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    stall_wdog #(
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_stall_wdog (
        .clk         (clk),
        .rst         (rst),
        .pc_stalled  (stall[StallPc]),
        .wdog_timeout(wdog_timeout)
    );

endmodule
